// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: writes mepc, mcause, mtval in turn,
// then issues a one-cycle redirect to mtvec (trap) or mepc (mret).
module trap_sequencer #(
  parameter logic [11:0] CSR_NUM_MEPC   = 12'h341,
  parameter logic [11:0] CSR_NUM_MCAUSE = 12'h342,
  parameter logic [11:0] CSR_NUM_MTVAL  = 12'h343
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_TrapValid,
  input  logic [2:0]  i_ExceptionSource,
  input  logic [31:0] i_TrapPc,
  input  logic [31:0] i_TrapValue,
  input  logic        i_MretValid,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic        o_Ready,
  output logic        o_CsrWriteEnable,
  output logic [11:0] o_CsrNumber,
  output logic [31:0] o_CsrWriteData,
  output logic        o_Flush,
  output logic        o_RedirectValid,
  output logic [31:0] o_RedirectPc,
  output logic [2:0]  o_DbgState
);

  // Handshake: a request is taken on the rising edge where it is valid and
  // o_Ready is high; requests seen while o_Ready is low are dropped, not held.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_TVAL   = 3'd3,
    S_REDIRECT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] target_q, target_d;

  function automatic logic [3:0] map_cause(input logic [2:0] src);
    case (src)
      3'd0:    map_cause = 4'd0;
      3'd1:    map_cause = 4'd1;
      3'd2:    map_cause = 4'd2;
      3'd3:    map_cause = 4'd3;
      3'd4:    map_cause = 4'd4;
      3'd5:    map_cause = 4'd6;
      3'd6:    map_cause = 4'd11;
      default: map_cause = 4'd2;
    endcase
  endfunction

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      tval_q   <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tval_d   = tval_q;
    cause_d  = cause_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        // Trap takes priority over a same-cycle mret; mtvec mode bits ignored.
        if (i_TrapValid) begin
          pc_d     = i_TrapPc;
          tval_d   = i_TrapValue;
          cause_d  = map_cause(i_ExceptionSource);
          target_d = {i_mtvec[31:2], 2'b00};
          state_d  = S_W_EPC;
        end else if (i_MretValid) begin
          target_d = {i_mepc[31:2], 2'b00};
          state_d  = S_REDIRECT;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_TVAL;
      S_W_TVAL:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Ready          = 1'b0;
    o_CsrWriteEnable = 1'b0;
    o_CsrNumber      = '0;
    o_CsrWriteData   = '0;
    o_Flush          = 1'b1;
    o_RedirectValid  = 1'b0;
    o_RedirectPc     = '0;
    case (state_q)
      S_IDLE: begin
        o_Ready = 1'b1;
        o_Flush = 1'b0;
      end
      S_W_EPC: begin
        o_CsrWriteEnable = 1'b1;
        o_CsrNumber      = CSR_NUM_MEPC;
        o_CsrWriteData   = {pc_q[31:2], 2'b00};
      end
      S_W_CAUSE: begin
        o_CsrWriteEnable = 1'b1;
        o_CsrNumber      = CSR_NUM_MCAUSE;
        o_CsrWriteData   = {28'd0, cause_q};
      end
      S_W_TVAL: begin
        o_CsrWriteEnable = 1'b1;
        o_CsrNumber      = CSR_NUM_MTVAL;
        o_CsrWriteData   = tval_q;
      end
      S_REDIRECT: begin
        o_RedirectValid = 1'b1;
        o_RedirectPc    = target_q;
      end
      default: begin
        o_Ready = 1'b1;
        o_Flush = 1'b0;
      end
    endcase
  end

  assign o_DbgState = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic, each cycle's
// outputs compared against a queue of expected per-cycle output bundles.
module tb_trap_sequencer;

  localparam int W = 80;
  localparam logic [W-1:0] IDLE_V = {1'b1, 79'd0};

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_TrapValid = 1'b0;
  logic [2:0]  i_ExceptionSource = '0;
  logic [31:0] i_TrapPc = '0;
  logic [31:0] i_TrapValue = '0;
  logic        i_MretValid = 1'b0;
  logic [31:0] i_mtvec = '0;
  logic [31:0] i_mepc = '0;
  logic        o_Ready;
  logic        o_CsrWriteEnable;
  logic [11:0] o_CsrNumber;
  logic [31:0] o_CsrWriteData;
  logic        o_Flush;
  logic        o_RedirectValid;
  logic [31:0] o_RedirectPc;
  logic [2:0]  o_DbgState;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int cause_lut[8] = '{0, 1, 2, 3, 4, 6, 11, 2};

  trap_sequencer dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_TrapValid(i_TrapValid),
    .i_ExceptionSource(i_ExceptionSource), .i_TrapPc(i_TrapPc),
    .i_TrapValue(i_TrapValue), .i_MretValid(i_MretValid), .i_mtvec(i_mtvec),
    .i_mepc(i_mepc), .o_Ready(o_Ready), .o_CsrWriteEnable(o_CsrWriteEnable),
    .o_CsrNumber(o_CsrNumber), .o_CsrWriteData(o_CsrWriteData), .o_Flush(o_Flush),
    .o_RedirectValid(o_RedirectValid), .o_RedirectPc(o_RedirectPc),
    .o_DbgState(o_DbgState)
  );

  // Clock / reset
  always #5 i_Clock = ~i_Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wr(input logic [11:0] num, input logic [31:0] data);
    return {1'b0, 1'b1, 1'b1, num, data, 1'b0, 32'd0};
  endfunction

  function automatic logic [W-1:0] redir(input logic [31:0] pc);
    return {1'b0, 1'b1, 1'b0, 12'd0, 32'd0, 1'b1, {pc[31:2], 2'b00}};
  endfunction

  task automatic compare_outputs(input logic [W-1:0] e);
    check_val("ready",    {31'd0, o_Ready},          {31'd0, e[79]});
    check_val("flush",    {31'd0, o_Flush},          {31'd0, e[78]});
    check_val("csr_we",   {31'd0, o_CsrWriteEnable}, {31'd0, e[77]});
    check_val("csr_num",  {20'd0, o_CsrNumber},      {20'd0, e[76:65]});
    check_val("csr_data", o_CsrWriteData,            e[64:33]);
    check_val("redir_v",  {31'd0, o_RedirectValid},  {31'd0, e[32]});
    check_val("redir_pc", o_RedirectPc,              e[31:0]);
  endtask

  // Scoreboard: one expected bundle per cycle; empty queue means IDLE.
  task automatic observe_cycle();
    bit idle;
    logic [W-1:0] e;
    idle = (exp_q.size() == 0);
    e = idle ? IDLE_V : exp_q.pop_front();
    compare_outputs(e);
    if (idle && i_TrapValid) begin
      exp_q.push_back(wr(12'h341, {i_TrapPc[31:2], 2'b00}));
      exp_q.push_back(wr(12'h342, cause_lut[i_ExceptionSource]));
      exp_q.push_back(wr(12'h343, i_TrapValue));
      exp_q.push_back(redir(i_mtvec));
    end else if (idle && i_MretValid) begin
      exp_q.push_back(redir(i_mepc));
    end
  endtask

  // Driver: called just after a rising edge; inputs hold for one full cycle.
  task automatic step(input logic trap, input logic [2:0] src, input logic [31:0] pc,
                      input logic [31:0] val, input logic mret,
                      input logic [31:0] mtvec, input logic [31:0] mepc);
    i_TrapValid = trap; i_ExceptionSource = src; i_TrapPc = pc; i_TrapValue = val;
    i_MretValid = mret; i_mtvec = mtvec; i_mepc = mepc;
    @(negedge i_Clock);
    observe_cycle();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle_steps(input int n, input logic [31:0] mtvec);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, mtvec, 32'd0);
  endtask

  task automatic mid_reset();
    i_TrapValid = 1'b0; i_MretValid = 1'b0;
    i_Reset_n = 1'b0;
    #1;
    compare_outputs(IDLE_V);
    exp_q.delete();
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    @(posedge i_Clock);
    #1;
  endtask

  initial begin
    #12;
    compare_outputs(IDLE_V);
    @(posedge i_Clock);
    #1;
    i_Reset_n = 1'b1;
    idle_steps(2, 32'd0);

    // Illegal instruction trap
    step(1'b1, 3'd2, 32'h0000_0106, 32'hDEAD_BEEF, 1'b0, 32'h0000_0203, 32'd0);
    idle_steps(5, 32'h0000_0203);

    // mret
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0203, 32'h0000_1002);
    idle_steps(3, 32'h0000_0203);

    // Trap and mret together: trap wins
    step(1'b1, 3'd6, 32'h0000_2000, 32'd0, 1'b1, 32'h0000_0300, 32'h0000_5554);
    idle_steps(5, 32'h0000_0300);

    // Second trap during W_CAUSE ignored, then back-to-back trap in cycle 5
    step(1'b1, 3'd1, 32'h0000_3008, 32'h1234_5678, 1'b0, 32'h0000_0200, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0200, 32'd0);
    step(1'b1, 3'd4, 32'h0000_9999, 32'hFFFF_FFFF, 1'b1, 32'h0000_0800, 32'h0000_0700);
    idle_steps(2, 32'h0000_0200);
    step(1'b1, 3'd7, 32'h0000_4444, 32'h0000_0001, 1'b0, 32'h0000_0200, 32'd0);

    // mtvec change during W_TVAL has no effect
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0200, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0200, 32'd0);
    idle_steps(4, 32'h0000_0400);

    // Reset during W_CAUSE aborts the sequence
    step(1'b1, 3'd5, 32'h0000_0ABC, 32'h0000_00EE, 1'b0, 32'h0000_0200, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h0000_0200, 32'd0);
    mid_reset();
    idle_steps(6, 32'h0000_0200);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      else step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 3) == 0, $urandom, $urandom);
    end
    idle_steps(6, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences machine-mode trap entry and `mret` return for the single-hart core. It sits between the execute stage and the CSR file:
- accepts an exception request (cause code, faulting PC, trap value) or an `mret`;
- drives the CSR file's machine-write port to update `mepc`, `mcause` and `mtval` over successive cycles;
- flushes the pipeline and issues a one-cycle PC redirect to `mtvec` (trap) or `mepc` (`mret`).

## Interface
Parameters:
- `CSR_NUM_MEPC`, default `12'h341`: CSR number written with the faulting PC.
- `CSR_NUM_MCAUSE`, default `12'h342`: CSR number written with the cause.
- `CSR_NUM_MTVAL`, default `12'h343`: CSR number written with the trap value.

Ports:
- `i_Clock`  in  1  sole clock, rising edge.
- `i_Reset_n`  in  1  reset, asynchronous, active-low.
- `i_TrapValid`  in  1  exception request from execute.
- `i_ExceptionSource`  in  3  encoded exception source.
- `i_TrapPc`  in  32  PC of the faulting instruction.
- `i_TrapValue`  in  32  value for `mtval` (bad address or instruction bits; 0 if none).
- `i_MretValid`  in  1  `mret` retiring in execute.
- `i_mtvec`  in  32  current `mtvec` from the CSR file.
- `i_mepc`  in  32  current `mepc` from the CSR file.
- `o_Ready`  out  1  high in IDLE; requests are accepted only when high.
- `o_CsrWriteEnable`  out  1  machine write strobe to the CSR file.
- `o_CsrNumber`  out  12  CSR being written.
- `o_CsrWriteData`  out  32  data for that write.
- `o_Flush`  out  1  squash all younger in-flight instructions.
- `o_RedirectValid`  out  1  one-cycle PC redirect strobe.
- `o_RedirectPc`  out  32  redirect target.

## Operation
States: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT.

Cause mapping, latched at accept:
- source 0 → `mcause` 0 (instruction misaligned)
- source 1 → 1 (instruction access fault)
- source 2 → 2 (illegal instruction)
- source 3 → 3 (breakpoint)
- source 4 → 4 (load misaligned)
- source 5 → 6 (store misaligned)
- source 6 → 11 (ecall from M)
- source 7 → 2 (reserved, treated as illegal)
- `mcause[31]` is always 0; interrupts are out of scope.

IDLE behaviour:
- `i_TrapValid`=1: latch PC, trap value, cause and `{i_mtvec[31:2],2'b00}` as target. Go to W_EPC. `mtvec` mode bits are ignored; the target is always the direct base.
- else `i_MretValid`=1: latch `{i_mepc[31:2],2'b00}` as target. Go to REDIRECT. No CSR writes.
- Both asserted in the same cycle: the trap wins and the `mret` is dropped.
- Neither asserted: stay in IDLE.

Trap write sequence:
- W_EPC: write `o_CsrNumber`=`CSR_NUM_MEPC`, `o_CsrWriteData`={PC[31:2],2'b00}. Next state W_CAUSE.
- W_CAUSE: write `CSR_NUM_MCAUSE` with the zero-extended cause. Next state W_TVAL.
- W_TVAL: write `CSR_NUM_MTVAL` with the trap value. Next state REDIRECT.
- REDIRECT: `o_RedirectValid`=1, `o_RedirectPc`=target. Next state IDLE.

Output rules:
- `o_CsrWriteEnable` is 1 only in W_EPC, W_CAUSE and W_TVAL.
- `o_CsrNumber` and `o_CsrWriteData` are 0 whenever the write strobe is low.
- `o_Flush` is 1 in every non-IDLE state.
- `o_Ready` is 1 only in IDLE.
- All outputs are decoded from registered state and latched data; there are no combinational paths from inputs to outputs.
- Requests arriving while not in IDLE are ignored, not queued. Upstream sees `o_Flush` and squashes them.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, all latched data 0.
- Outputs during reset: `o_Ready`=1; all other outputs 0.
- Reset asserted mid-sequence: return to IDLE immediately. CSR writes already issued stand; remaining writes and the redirect are not issued.
- Trap latency, with accept at edge 0:
  - W_EPC during cycle 1;
  - W_CAUSE during cycle 2;
  - W_TVAL during cycle 3;
  - REDIRECT during cycle 4;
  - `o_Ready`=1 again in cycle 5.
  - Total: 5 cycles from request to readiness.
- `mret` latency: accept at edge 0, REDIRECT during cycle 1, IDLE in cycle 2.
- `o_RedirectValid` is exactly one cycle wide.
- Writes are issued in strict order `mepc`, `mcause`, `mtval`, one per cycle.
- Target address is captured at accept. Changes to `i_mtvec` or `i_mepc` after accept have no effect, including the sequence's own `mepc` write.
- A request presented in cycle 5, the first IDLE cycle after a sequence, is accepted.

## Test plan
- Reset: hold `i_Reset_n`=0 → `o_Ready`=1, all other outputs 0; release → remain IDLE.
- Illegal instruction: source=2, PC=`0x0000_0106`, value=`0xDEAD_BEEF`, `mtvec`=`0x0000_0203`. Required response:
  - cycle 1: write 0x341 ← `0x0000_0104`;
  - cycle 2: write 0x342 ← 2;
  - cycle 3: write 0x343 ← `0xDEAD_BEEF`;
  - cycle 4: redirect to `0x0000_0200`;
  - `o_Flush` high throughout cycles 1–4.
- `mret` with `i_mepc`=`0x0000_1002` → no CSR writes; redirect `0x0000_1000` in cycle 1; `o_Ready` high in cycle 2.
- Simultaneous trap (source=6) and `mret` → full trap sequence with `mcause`=11; no `mret` redirect at any point.
- Second `i_TrapValid` pulsed during W_CAUSE → ignored: exactly three writes and one redirect. Then a trap with source=7 in cycle 5 → accepted, `mcause`=2.
- Change `i_mtvec` to `0x0000_0400` during W_TVAL → redirect still `0x0000_0200`. Separately, assert reset during W_CAUSE → only the `mepc` write was issued and no redirect follows.
